// File: rtl/ula_serial_controle_if.sv
// Request/result bundle for the bit-serial ALU.
// The requester drives the start strobe, operands and operation select;
// the ALU returns busy/done status and the registered result flags.
interface ula_serial_controle_if #(
   parameter int LARGURA = 8
);
   logic               inicio;
   logic [LARGURA-1:0] entrada1;
   logic [LARGURA-1:0] entrada2;
   logic [1:0]         seletor;
   logic               ocupado;
   logic               pronto;
   logic [LARGURA-1:0] saida;
   logic               carry_out;
   logic               zero;

   // Requester side.
   modport master (
      output inicio, entrada1, entrada2, seletor,
      input  ocupado, pronto, saida, carry_out, zero
   );

   // ALU side.
   modport slave (
      input  inicio, entrada1, entrada2, seletor,
      output ocupado, pronto, saida, carry_out, zero
   );
endinterface

// File: rtl/ula_serial_controle.sv
// Bit-serial ALU: add, subtract, AND and OR processed one bit per clock,
// LSB first. Operands are latched when a request is accepted in the idle
// state; the published result only changes on the commit edge, so callers
// never observe a partially built word.
module ula_serial_controle #(
   parameter int LARGURA = 8
) (
   input logic                 clock,
   input logic                 reset,
   ula_serial_controle_if.slave bus
);

   // One extra index value marks the commit step after the last bit.
   localparam int IDX_W = $clog2(LARGURA + 1);
   localparam logic [IDX_W-1:0] IDX_COMMIT = IDX_W'(LARGURA);

   localparam logic [1:0] SEL_SOMA = 2'b00;
   localparam logic [1:0] SEL_SUB  = 2'b01;
   localparam logic [1:0] SEL_AND  = 2'b10;
   localparam logic [1:0] SEL_OR   = 2'b11;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      CALCULA = 2'd1,
      CONCLUI = 2'd2
   } estado_t;

   estado_t            state_reg, state_next;
   logic [LARGURA-1:0] a_reg, a_next;
   logic [LARGURA-1:0] b_reg, b_next;
   logic [1:0]         sel_reg, sel_next;
   logic [IDX_W-1:0]   idx_reg, idx_next;
   logic               carry_reg, carry_next;
   logic [LARGURA-1:0] acc_reg, acc_next;
   logic [LARGURA-1:0] saida_reg, saida_next;
   logic               carry_out_reg, carry_out_next;
   logic               zero_reg, zero_next;

   // Per-bit datapath signals for the current index.
   logic bit_a;
   logic bit_b;
   logic bit_res;
   logic carry_bit;

   // Select the operand bit pair at the current index and evaluate one bit slice.
   always_comb begin
      bit_a     = 1'b0;
      bit_b     = 1'b0;
      bit_res   = 1'b0;
      carry_bit = carry_reg;
      for (int i = 0; i < LARGURA; i++) begin
         if (idx_reg == IDX_W'(i)) begin
            bit_a = a_reg[i];
            bit_b = b_reg[i];
         end
      end
      // Subtraction is A + ~B + 1: invert B here, the +1 comes from the carry seed.
      if (sel_reg == SEL_SUB) begin
         bit_b = ~bit_b;
      end
      case (sel_reg)
         SEL_SOMA, SEL_SUB: begin
            bit_res   = bit_a ^ bit_b ^ carry_reg;
            carry_bit = (bit_a & bit_b) | (bit_a & carry_reg) | (bit_b & carry_reg);
         end
         SEL_AND: bit_res = bit_a & bit_b;
         SEL_OR:  bit_res = bit_a | bit_b;
         default: bit_res = 1'b0;
      endcase
   end

   // Next-state logic: request acceptance, serial bit steps and result commit.
   always_comb begin
      state_next     = state_reg;
      a_next         = a_reg;
      b_next         = b_reg;
      sel_next       = sel_reg;
      idx_next       = idx_reg;
      carry_next     = carry_reg;
      acc_next       = acc_reg;
      saida_next     = saida_reg;
      carry_out_next = carry_out_reg;
      zero_next      = zero_reg;

      case (state_reg)
         OCIOSO: begin
            if (bus.inicio) begin
               a_next     = bus.entrada1;
               b_next     = bus.entrada2;
               sel_next   = bus.seletor;
               idx_next   = '0;
               carry_next = (bus.seletor == SEL_SUB);
               acc_next   = '0;
               state_next = CALCULA;
            end
         end

         CALCULA: begin
            if (idx_reg == IDX_COMMIT) begin
               // All bits done: publish the word and its flags together.
               saida_next     = acc_reg;
               carry_out_next = ((sel_reg == SEL_SOMA) || (sel_reg == SEL_SUB)) ? carry_reg : 1'b0;
               zero_next      = (acc_reg == '0);
               state_next     = CONCLUI;
            end else begin
               for (int i = 0; i < LARGURA; i++) begin
                  if (idx_reg == IDX_W'(i)) begin
                     acc_next[i] = bit_res;
                  end
               end
               carry_next = carry_bit;
               idx_next   = idx_reg + IDX_W'(1);
            end
         end

         CONCLUI: begin
            // Requests seen here are dropped; a new start must be held in OCIOSO.
            state_next = OCIOSO;
         end

         default: begin
            state_next = OCIOSO;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= OCIOSO;
         a_reg         <= '0;
         b_reg         <= '0;
         sel_reg       <= SEL_SOMA;
         idx_reg       <= '0;
         carry_reg     <= 1'b0;
         acc_reg       <= '0;
         saida_reg     <= '0;
         carry_out_reg <= 1'b0;
         zero_reg      <= 1'b1;
      end else begin
         state_reg     <= state_next;
         a_reg         <= a_next;
         b_reg         <= b_next;
         sel_reg       <= sel_next;
         idx_reg       <= idx_next;
         carry_reg     <= carry_next;
         acc_reg       <= acc_next;
         saida_reg     <= saida_next;
         carry_out_reg <= carry_out_next;
         zero_reg      <= zero_next;
      end
   end

   assign bus.ocupado   = (state_reg != OCIOSO);
   assign bus.pronto    = (state_reg == CONCLUI);
   assign bus.saida     = saida_reg;
   assign bus.carry_out = carry_out_reg;
   assign bus.zero      = zero_reg;

endmodule

// File: tb/tb_ula_serial_controle.sv
// Self-checking bench for the bit-serial ALU (LARGURA = 8).
// Expected results come from a word-level arithmetic model and are queued
// when a request is driven, then popped when pronto is observed.
module tb_ula_serial_controle;

   localparam int W = 8;
   localparam logic [1:0] OP_SOMA = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_AND  = 2'b10;
   localparam logic [1:0] OP_OR   = 2'b11;

   logic clock = 1'b0;
   logic reset = 1'b1;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;
   int pronto_count = 0;
   logic [W-1:0] last_saida = '0;

   typedef struct {
      logic [W-1:0] saida;
      logic         carry_out;
      logic         zero;
      int           due;
   } exp_t;

   exp_t exp_q[$];

   ula_serial_controle_if #(.LARGURA(W)) bus ();

   ula_serial_controle #(.LARGURA(W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (bus.pronto === 1'b1) pronto_count <= pronto_count + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
      exp_t e;
      logic [W:0] wide;
      e.carry_out = 1'b0;
      e.due       = 0;
      case (op)
         OP_SOMA: begin
            wide        = {1'b0, a} + {1'b0, b};
            e.saida     = wide[W-1:0];
            e.carry_out = wide[W];
         end
         OP_SUB: begin
            e.saida     = a - b;
            e.carry_out = (a >= b);
         end
         OP_AND:  e.saida = a & b;
         default: e.saida = a | b;
      endcase
      e.zero = (e.saida == '0);
      return e;
   endfunction

   // Present a request at a falling edge; it is accepted on the next rising edge.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                           input bit hold_inicio);
      exp_t e;
      @(negedge clock);
      bus.entrada1 = a;
      bus.entrada2 = b;
      bus.seletor  = op;
      bus.inicio   = 1'b1;
      @(posedge clock);
      #1;
      e     = model(a, b, op);
      e.due = cyc + W + 1;
      exp_q.push_back(e);
      if (!hold_inicio) bus.inicio = 1'b0;
   endtask

   task automatic wait_pronto(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clock);
         if (bus.pronto === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      bus.inicio = 1'b1;
      repeat (3) @(negedge clock);
      tests_run++;
      if (bus.saida !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_saida: got %h expected 00", bus.saida);
      end
      tests_run++;
      if (bus.carry_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_carry_out: got %b expected 0", bus.carry_out);
      end
      tests_run++;
      if (bus.zero !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_zero: got %b expected 1", bus.zero);
      end
      tests_run++;
      if (bus.pronto !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_pronto: got %b expected 0", bus.pronto);
      end
      tests_run++;
      if (bus.ocupado !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_ocupado: got %b expected 0", bus.ocupado);
      end
      bus.inicio = 1'b0;
      reset      = 1'b0;
      last_saida = '0;
      $display("[TB] reset: outputs checked");
   endtask

   task automatic test_operations();
      logic [W-1:0] tab_a [8] = '{8'h5A, 8'hFF, 8'h10, 8'h01, 8'hF0, 8'h00, 8'hFF, 8'hF0};
      logic [W-1:0] tab_b [8] = '{8'h3C, 8'h01, 8'h01, 8'h02, 8'h3C, 8'h00, 8'hFF, 8'h0F};
      logic [1:0]   tab_op[8] = '{OP_SOMA, OP_SOMA, OP_SUB, OP_SUB, OP_AND, OP_SUB, OP_SOMA, OP_OR};
      logic [W-1:0] a, b;
      logic [1:0]   op;
      exp_t         e;
      bit           seen;
      for (int n = 0; n < 12; n++) begin
         if (n < 4) begin
            a  = W'($urandom_range(0, 255));
            b  = W'($urandom_range(0, 255));
            op = 2'($urandom_range(0, 3));
         end else begin
            a  = tab_a[n-4];
            b  = tab_b[n-4];
            op = tab_op[n-4];
         end
         start_op(a, b, op, 1'b0);
         @(negedge clock);
         tests_run++;
         if (bus.ocupado !== 1'b1) begin
            tests_failed++;
            $display("FAIL op%0d_ocupado: got %b expected 1", n, bus.ocupado);
         end
         tests_run++;
         if (bus.saida !== last_saida) begin
            tests_failed++;
            $display("FAIL op%0d_saida_hold: got %h expected %h", n, bus.saida, last_saida);
         end
         wait_pronto(seen);
         e = exp_q.pop_front();
         tests_run++;
         if (!seen) begin
            tests_failed++;
            $display("FAIL op%0d_timeout: pronto not seen, expected at cycle %0d", n, e.due);
            continue;
         end
         $display("[TB] op%0d a=%h b=%h sel=%b -> saida=%h carry=%b zero=%b (exp %h %b %b) cyc=%0d",
                  n, a, b, op, bus.saida, bus.carry_out, bus.zero, e.saida, e.carry_out, e.zero, cyc);
         tests_run++;
         if (cyc !== e.due) begin
            tests_failed++;
            $display("FAIL op%0d_latency: pronto at cycle %0d expected %0d", n, cyc, e.due);
         end
         tests_run++;
         if (bus.saida !== e.saida) begin
            tests_failed++;
            $display("FAIL op%0d_saida: got %h expected %h", n, bus.saida, e.saida);
         end
         tests_run++;
         if (bus.carry_out !== e.carry_out) begin
            tests_failed++;
            $display("FAIL op%0d_carry_out: got %b expected %b", n, bus.carry_out, e.carry_out);
         end
         tests_run++;
         if (bus.zero !== e.zero) begin
            tests_failed++;
            $display("FAIL op%0d_zero: got %b expected %b", n, bus.zero, e.zero);
         end
         last_saida = e.saida;
         @(negedge clock);
         tests_run++;
         if (bus.pronto !== 1'b0) begin
            tests_failed++;
            $display("FAIL op%0d_pronto_width: got %b expected 0", n, bus.pronto);
         end
         tests_run++;
         if (bus.ocupado !== 1'b0 || bus.saida !== e.saida) begin
            tests_failed++;
            $display("FAIL op%0d_after: ocupado=%b saida=%h expected 0 %h", n, bus.ocupado, bus.saida, e.saida);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      exp_t e2;
      bit   seen;
      int   pc;
      start_op(8'h12, 8'h34, OP_SOMA, 1'b1);
      #1;
      pc = pronto_count;
      repeat (3) @(negedge clock);
      bus.entrada1 = 8'h80;
      bus.entrada2 = 8'h05;
      bus.seletor  = OP_SUB;
      e2     = model(8'h80, 8'h05, OP_SUB);
      e2.due = exp_q[0].due + W + 3;
      exp_q.push_back(e2);
      @(negedge clock);
      tests_run++;
      if (bus.saida !== last_saida) begin
         tests_failed++;
         $display("FAIL b2b_partial: got %h expected %h", bus.saida, last_saida);
      end
      for (int k = 0; k < 2; k++) begin
         wait_pronto(seen);
         e = exp_q.pop_front();
         tests_run++;
         if (!seen) begin
            tests_failed++;
            $display("FAIL b2b%0d_timeout: pronto not seen, expected at cycle %0d", k, e.due);
            continue;
         end
         $display("[TB] b2b%0d saida=%h carry=%b zero=%b (exp %h %b %b) cyc=%0d",
                  k, bus.saida, bus.carry_out, bus.zero, e.saida, e.carry_out, e.zero, cyc);
         tests_run++;
         if (cyc !== e.due) begin
            tests_failed++;
            $display("FAIL b2b%0d_latency: pronto at cycle %0d expected %0d", k, cyc, e.due);
         end
         tests_run++;
         if (bus.saida !== e.saida || bus.carry_out !== e.carry_out || bus.zero !== e.zero) begin
            tests_failed++;
            $display("FAIL b2b%0d_result: got %h/%b/%b expected %h/%b/%b", k,
                     bus.saida, bus.carry_out, bus.zero, e.saida, e.carry_out, e.zero);
         end
         last_saida = e.saida;
      end
      bus.inicio = 1'b0;
      repeat (15) @(negedge clock);
      #1;
      tests_run++;
      if (pronto_count !== pc + 2) begin
         tests_failed++;
         $display("FAIL b2b_pronto_count: got %0d expected %0d", pronto_count - pc, 2);
      end
   endtask

   task automatic test_reset_abort();
      exp_t e;
      bit   seen;
      int   pc;
      start_op(8'h33, 8'h44, OP_SOMA, 1'b0);
      void'(exp_q.pop_back());
      #1;
      pc = pronto_count;
      repeat (4) @(negedge clock);
      reset        = 1'b1;
      bus.inicio   = 1'b1;
      bus.entrada1 = 8'h7F;
      bus.entrada2 = 8'h01;
      bus.seletor  = OP_SOMA;
      @(negedge clock);
      tests_run++;
      if (bus.saida !== 8'h00 || bus.carry_out !== 1'b0 || bus.zero !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort_outputs: got %h/%b/%b expected 00/0/1", bus.saida, bus.carry_out, bus.zero);
      end
      tests_run++;
      if (bus.pronto !== 1'b0 || bus.ocupado !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_status: pronto=%b ocupado=%b expected 0 0", bus.pronto, bus.ocupado);
      end
      last_saida = '0;
      reset = 1'b0;
      @(posedge clock);
      #1;
      e     = model(8'h7F, 8'h01, OP_SOMA);
      e.due = cyc + W + 1;
      exp_q.push_back(e);
      bus.inicio = 1'b0;
      wait_pronto(seen);
      e = exp_q.pop_front();
      #1;
      tests_run++;
      if (!seen) begin
         tests_failed++;
         $display("FAIL abort_timeout: pronto not seen, expected at cycle %0d", e.due);
      end else begin
         $display("[TB] after abort saida=%h carry=%b zero=%b (exp %h %b %b) cyc=%0d",
                  bus.saida, bus.carry_out, bus.zero, e.saida, e.carry_out, e.zero, cyc);
         tests_run++;
         if (pronto_count !== pc + 1) begin
            tests_failed++;
            $display("FAIL abort_pronto_count: got %0d expected 1", pronto_count - pc);
         end
         tests_run++;
         if (cyc !== e.due) begin
            tests_failed++;
            $display("FAIL abort_latency: pronto at cycle %0d expected %0d", cyc, e.due);
         end
         tests_run++;
         if (bus.saida !== e.saida || bus.carry_out !== e.carry_out || bus.zero !== e.zero) begin
            tests_failed++;
            $display("FAIL abort_result: got %h/%b/%b expected %h/%b/%b",
                     bus.saida, bus.carry_out, bus.zero, e.saida, e.carry_out, e.zero);
         end
      end
   endtask

   initial begin
      bus.inicio   = 1'b0;
      bus.entrada1 = '0;
      bus.entrada2 = '0;
      bus.seletor  = OP_SOMA;
      test_reset();
      test_operations();
      test_back_to_back();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ula_serial_controle.md
ULA_SERIAL_CONTROLE -- requirements
Module: ula_serial_controle

Interface
REQ-001 Parameter: LARGURA, default 8, operand/result width in bits (SHALL be >= 2).
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 inicio  input  1  start request; sampled only in state OCIOSO.
REQ-005 entrada1  input  LARGURA  operand A; captured on the accepting edge.
REQ-006 entrada2  input  LARGURA  operand B; captured on the accepting edge.
REQ-007 seletor  input  2  operation: 00 soma, 01 subtracao, 10 AND, 11 OR; captured on the accepting edge.
REQ-008 ocupado  output  1  high while a request is in progress (CALCULA or CONCLUI).
REQ-009 pronto  output  1  one-cycle pulse marking valid result.
REQ-010 saida  output  LARGURA  registered result.
REQ-011 carry_out  output  1  final carry of soma/subtracao; 0 for AND/OR.
REQ-012 zero  output  1  high when saida == 0.

Function
REQ-013 FSM states SHALL be OCIOSO, CALCULA, CONCLUI.
REQ-014 OCIOSO with inicio=1 at an edge: latch operands/seletor, clear bit index to 0, go to CALCULA; otherwise stay.
REQ-015 CALCULA: one bit per cycle, LSB first, using the latched bit pair, internal carry and latched seletor; result bit stored at current index; index increments.
REQ-016 Soma: bit = a^b^c, carry = majority(a,b,c); carry starts at 0.
REQ-017 Subtracao: A + ~B + 1 -- B bit inverted, carry starts at 1; carry_out=1 means no borrow (A >= B unsigned).
REQ-018 AND/OR: bitwise per bit; internal carry ignored; carry_out SHALL be 0.
REQ-019 After LARGURA CALCULA edges: saida, carry_out, zero updated on the same edge; go to CONCLUI.
REQ-020 CONCLUI: pronto=1 for exactly that cycle; next edge returns to OCIOSO unconditionally.
REQ-021 Latency: accept at edge k -> pronto high between edges k+LARGURA+1 and k+LARGURA+2; saida valid from edge k+LARGURA+1.
REQ-022 ocupado SHALL be high from the accepting edge until the edge leaving CONCLUI.
REQ-023 inicio in CALCULA or CONCLUI SHALL be ignored (not queued); back-to-back starts require inicio high in OCIOSO.
REQ-024 Operand/seletor input changes after acceptance SHALL NOT affect the running operation.
REQ-025 saida, carry_out, zero SHALL hold their last values until the next completion; partial results never appear on saida.
REQ-026 Overflow wraps modulo 2^LARGURA; carry_out is the only overflow indicator.

Reset
REQ-027 reset=1 at an edge SHALL force OCIOSO, saida=0, carry_out=0, zero=1, pronto=0, ocupado=0, index and internal carry cleared.
REQ-028 reset during CALCULA or CONCLUI SHALL abort the operation with no pronto pulse; reset wins over simultaneous inicio.
REQ-029 First edge after reset release with inicio=1 SHALL be accepted normally.

Verification (LARGURA=8)
REQ-030 soma 0x5A+0x3C -> saida=0x96, carry_out=0, zero=0, pronto at accept+9 cycles.
REQ-031 soma 0xFF+0x01 -> saida=0x00, carry_out=1, zero=1.
REQ-032 subtracao 0x10-0x01 -> 0x0F, carry_out=1; subtracao 0x01-0x02 -> 0xFF, carry_out=0.
REQ-033 AND 0xF0&0x3C -> 0x30, carry_out=0; OR 0xF0|0x0F -> 0xFF, zero=0.
REQ-034 inicio held high with operands changed mid-CALCULA -> first result unaffected, one pronto per OCIOSO acceptance, second op accepted only after CONCLUI.
REQ-035 reset asserted 4 cycles into CALCULA -> no pronto, outputs at reset values, next request completes correctly.
